// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, fetch FSM encoding and the canonical NOP.
// Imported by the fetch, decode and execute stages.
package riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    FS_IDLE = 3'd0,
    FS_REQ  = 3'd1,
    FS_WAIT = 3'd2,
    FS_KILL = 3'd3,
    FS_HOLD = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: imem request/response, held inst, PC steering.
// Optional FETCH_PERF_EN adds fetch_stall_cnt / fetch_cnt counters.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = riscv_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_misalign
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_stall_cnt,
  output logic [31:0] fetch_cnt
`endif
);
  import riscv_pkg::*;

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  inst_q;
  logic [31:0]  rpc;
  logic         hs;
  logic         load;

  assign rpc = redirect_pc & ~32'h3;
  assign hs  = (state == FS_REQ) & imem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FS_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    load      = 1'b0;
    unique case (state)
      FS_IDLE: state_nxt = FS_REQ;
      FS_REQ: begin
        if (redirect) pc_nxt = rpc;
        if (hs) state_nxt = redirect ? FS_KILL : FS_WAIT;
      end
      FS_WAIT: begin
        if (redirect) pc_nxt = rpc;
        if (imem_rvalid) begin
          state_nxt = redirect ? FS_REQ : FS_HOLD;
          load      = !redirect;
        end else if (redirect) begin
          state_nxt = FS_KILL;
        end
      end
      // Stale response still in flight; only its arrival frees the bus.
      FS_KILL: begin
        if (redirect) pc_nxt = rpc;
        if (imem_rvalid) state_nxt = FS_REQ;
      end
      FS_HOLD: begin
        if (redirect) begin
          pc_nxt    = rpc;
          state_nxt = FS_REQ;
        end else if (inst_ready) begin
          pc_nxt    = pc + 32'd4;
          state_nxt = FS_REQ;
        end
      end
      default: state_nxt = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      inst_q         <= NOP_INST;
      inst_pc        <= RESET_PC;
      fetch_misalign <= 1'b0;
    end else begin
      pc             <= pc_nxt;
      fetch_misalign <= redirect & |redirect_pc[1:0];
      if (load) begin
        inst_q  <= imem_rdata;
        inst_pc <= pc;
      end
    end
  end

  assign imem_req   = (state == FS_REQ);
  assign imem_addr  = pc;
  assign inst_valid = (state == FS_HOLD);
  assign inst       = inst_valid ? inst_q : NOP_INST;

`ifdef FETCH_PERF_EN
  logic stall;

  assign stall = ((state == FS_REQ) & !imem_ready) |
                 (((state == FS_WAIT) | (state == FS_KILL)) & !imem_rvalid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_stall_cnt <= 32'd0;
      fetch_cnt       <= 32'd0;
    end else begin
      if (stall) fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
      if ((state == FS_HOLD) & inst_ready & !redirect)
        fetch_cnt <= fetch_cnt + 32'd1;
    end
  end
`else
  // Counters compiled out; fetch behaviour is unchanged.
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: vector table, corner sequences,
// and a randomized run against a transaction-level model.
module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_misalign;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_stall_cnt;
  logic [31:0] fetch_cnt;
`endif

  int nchk = 0;
  int nerr = 0;

  fetch_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .fetch_misalign(fetch_misalign)
`ifdef FETCH_PERF_EN
    ,
    .fetch_stall_cnt(fetch_stall_cnt),
    .fetch_cnt(fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          rdy_lat;
    int          rv_lat;
    logic [31:0] rdata;
    int          hold;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A00_0000;
  endfunction

  // From a negedge in REQ at addr: handshake now, rvalid next cycle, ends in HOLD.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data);
    chk("req", {31'd0, imem_req}, 32'd1);
    chk("req_addr", imem_addr, addr);
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("hold_valid", {31'd0, inst_valid}, 32'd1);
    chk("hold_inst", inst, data);
    chk("hold_pc", inst_pc, addr);
  endtask

  task automatic run_vec(input vec_t v);
    for (int i = 0; i < v.rdy_lat; i++) begin
      chk("bp_req", {31'd0, imem_req}, 32'd1);
      chk("bp_addr", imem_addr, v.addr);
      imem_ready = 1'b0;
      @(negedge clk);
    end
    chk("vec_addr", imem_addr, v.addr);
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    chk("wait_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < v.rv_lat; i++) begin
      chk("wait_valid", {31'd0, inst_valid}, 32'd0);
      @(negedge clk);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = v.rdata;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hFFFF_FFFF;
    for (int h = 0; h <= v.hold; h++) begin
      chk("vec_valid", {31'd0, inst_valid}, 32'd1);
      chk("vec_inst", inst, v.rdata);
      chk("vec_pc", inst_pc, v.addr);
      inst_ready = (h == v.hold);
      @(negedge clk);
    end
    inst_ready = 1'b0;
    chk("exit_valid", {31'd0, inst_valid}, 32'd0);
    chk("exit_nop", inst, NOP);
  endtask

  task automatic chk_reset();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_inst", inst, NOP);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_mis", {31'd0, fetch_misalign}, 32'd0);
`ifdef FETCH_PERF_EN
    chk("rst_stall_cnt", fetch_stall_cnt, 32'd0);
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
`endif
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic        mis_exp;
    logic        pend;
    int          pend_cnt;
    logic [31:0] pend_data;
    int          delivered;

    tbl[0] = '{0, 0, 32'h0050_0093, 0, 32'h0000_0000};
    tbl[1] = '{5, 0, 32'h0010_0113, 4, 32'h0000_0004};
    tbl[2] = '{1, 2, 32'h0020_8193, 1, 32'h0000_0008};
    tbl[3] = '{0, 1, 32'h4000_0233, 2, 32'h0000_000C};

    repeat (3) @(negedge clk);
    chk_reset();
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_vec(tbl[i]);

    // Redirect in WAIT; stale response must be swallowed by KILL.
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    chk("kill_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("kill_valid", {31'd0, inst_valid}, 32'd0);
    chk("kill_inst", inst, NOP);
    do_fetch(32'h100, 32'h0000_0013);

    // Redirect plus inst_ready in HOLD: redirect wins.
    redirect    = 1'b1;
    inst_ready  = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    redirect   = 1'b0;
    inst_ready = 1'b0;
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_mis", {31'd0, fetch_misalign}, 32'd0);

    // Misaligned redirect while REQ stalls.
    redirect    = 1'b1;
    redirect_pc = 32'h46;
    @(negedge clk);
    redirect = 1'b0;
    chk("mis_pulse", {31'd0, fetch_misalign}, 32'd1);
    chk("mis_addr", imem_addr, 32'h44);
    @(negedge clk);
    chk("mis_clear", {31'd0, fetch_misalign}, 32'd0);

    // PC wrap at the top of the address space.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    do_fetch(32'hFFFF_FFFC, 32'h0030_0313);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    chk("wrap_addr", imem_addr, 32'h0);

    // Async reset in WAIT.
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'h0);

    // Randomized run against a transaction-level model.
    exp_pc = 32'h0; mis_exp = 1'b0; pend = 1'b0;
    pend_cnt = 0; pend_data = 32'h0; delivered = 0;
    for (int n = 0; n < 4000; n++) begin
      chk("r_mis", {31'd0, fetch_misalign}, {31'd0, mis_exp});
      if (imem_req) chk("r_addr", imem_addr, exp_pc);
      if (inst_valid) begin
        chk("r_pc", inst_pc, exp_pc);
        chk("r_inst", inst, memf(inst_pc));
      end else begin
        chk("r_nop", inst, NOP);
      end
      imem_ready  = ($urandom_range(0, 1) == 1);
      inst_ready  = ($urandom_range(0, 2) != 0);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = $urandom;
      if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (pend) begin
        if (pend_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = pend_data;
          pend        = 1'b0;
        end else begin
          pend_cnt--;
        end
      end else if ($urandom_range(0, 4) == 0) begin
        imem_rvalid = 1'b1;
      end
      mis_exp = redirect && (redirect_pc[1:0] != 2'b00);
      if (inst_valid && (redirect || inst_ready)) delivered++;
      if (redirect) exp_pc = redirect_pc & ~32'h3;
      else if (inst_valid && inst_ready) exp_pc = inst_pc + 32'd4;
      if (imem_req && imem_ready) begin
        pend      = 1'b1;
        pend_cnt  = $urandom_range(0, 2);
        pend_data = memf(imem_addr);
      end
      @(negedge clk);
    end
    redirect = 1'b0; imem_ready = 1'b0; inst_ready = 1'b0; imem_rvalid = 1'b0;
    chk("r_progress", {31'd0, delivered > 100}, 32'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
